// File: rtl/meter_pkg.sv
// meter_pkg: shared state encoding and default sizing for the pulse period meter.
package meter_pkg;
  localparam int CNT_W_DEF = 26;
  localparam int TIMEOUT_DEF = 50_000_000;
  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;
endpackage

// File: rtl/pulse_period_meter_if.sv
// pulse_period_meter_if: measured input and result bundle of the pulse period meter.
interface pulse_period_meter_if
  import meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  modport master(output sig_in, input period, high_time, valid, timeout);
  modport slave(input sig_in, output period, high_time, valid, timeout);
endinterface

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchroniser, history flop and edge strobes for an async input.
module sync_edge_detect (
  input  logic clkin,
  input  logic rst_n,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall,
  output logic primed
);
  logic s1, s2, s3;
  logic [1:0] warm;
  // primed marks the point where s2 reflects a real sample rather than its reset value
  always_ff @(posedge clkin or negedge rst_n)
    if (!rst_n) {s1, s2, s3, warm} <= '0;
    else {s1, s2, s3, warm} <= {sig, s1, s2, warm[0], 1'b1};
  assign level = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign primed = warm[1];
endmodule

// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures period and high time of an async square wave in clkin cycles.
module pulse_period_meter
  import meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clkin,
  input logic rst_n,
  pulse_period_meter_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  state_t state;
  logic [CNT_W-1:0] cnt, cnt_inc, hi_pend, period, high_time;
  logic valid, timeout, level, rise, fall, primed;
  sync_edge_detect u_sync (
    .clkin(clkin),
    .rst_n(rst_n),
    .sig(bus.sig_in),
    .level(level),
    .rise(rise),
    .fall(fall),
    .primed(primed)
  );
  assign cnt_inc = cnt + CNT_W'(1);
  always_ff @(posedge clkin or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      hi_pend <= '0;
      period <= '0;
      high_time <= '0;
      valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (primed && !level) state <= ARMED;
        end
        ARMED: begin
          cnt <= '0;
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          if (fall) hi_pend <= cnt_inc;
          // a rise on the last allowed cycle still counts, giving period == TIMEOUT
          if (rise) begin
            period <= cnt_inc;
            high_time <= hi_pend;
            valid <= 1'b1;
            timeout <= 1'b0;
            cnt <= '0;
          end else if (cnt == LAST) begin
            timeout <= 1'b1;
            cnt <= '0;
            state <= IDLE;
          end else cnt <= cnt_inc;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.period = period;
  assign bus.high_time = high_time;
  assign bus.valid = valid;
  assign bus.timeout = timeout;
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: scoreboard bench with a default-timeout meter and a TIMEOUT=100 meter.
module tb_pulse_period_meter;
  import meter_pkg::*;
  localparam int W = 26;
  logic clkin = 1'b0, rst_n = 1'b0, sig_a = 1'b0, sig_b = 1'b0, to_b = 1'b0;
  int checks = 0, errors = 0;
  logic [2*W-1:0] exp_a[$], obs_a[$], exp_b[$], obs_b[$];
  always #5 clkin = ~clkin;
  pulse_period_meter_if #(.CNT_W(W)) ia ();
  pulse_period_meter_if #(.CNT_W(W)) ib ();
  assign ia.sig_in = sig_a;
  assign ib.sig_in = sig_b;
  pulse_period_meter #(.CNT_W(W)) dut_a (.clkin(clkin), .rst_n(rst_n), .bus(ia));
  pulse_period_meter #(.CNT_W(W), .TIMEOUT(100)) dut_b (.clkin(clkin), .rst_n(rst_n), .bus(ib));
  always @(negedge clkin) begin
    if (ia.valid) obs_a.push_back({ia.period, ia.high_time});
    if (ib.valid) obs_b.push_back({ib.period, ib.high_time});
    if (ib.timeout) to_b = 1'b1;
  end
  task automatic drive(input bit b, input logic v);
    if (b) sig_b = v;
    else sig_a = v;
  endtask
  // n periods of hi/lo; rises with index >= skip are expected to produce a result
  task automatic wave(input bit b, input int hi, input int lo, input int n, input int skip);
    for (int i = 0; i < n; i++) begin
      drive(b, 1'b1);
      if (i >= skip) begin
        if (b) exp_b.push_back({W'(hi + lo), W'(hi)});
        else exp_a.push_back({W'(hi + lo), W'(hi)});
      end
      repeat (hi) @(posedge clkin);
      #1;
      drive(b, 1'b0);
      repeat (lo) @(posedge clkin);
      #1;
    end
  endtask
  task automatic apply_reset(input logic hold);
    rst_n = 1'b0;
    sig_a = hold;
    sig_b = 1'b0;
    repeat (3) @(posedge clkin);
    #1;
    checks++;
    if ({ia.period, ia.high_time, ia.valid, ia.timeout} !== '0) begin
      errors++;
      $display("FAIL reset_a: period %0d high %0d valid %b timeout %b, want all 0", ia.period, ia.high_time, ia.valid, ia.timeout);
    end
    checks++;
    if ({ib.period, ib.high_time, ib.valid, ib.timeout} !== '0) begin
      errors++;
      $display("FAIL reset_b: period %0d high %0d valid %b timeout %b, want all 0", ib.period, ib.high_time, ib.valid, ib.timeout);
    end
    exp_a.delete(); obs_a.delete(); exp_b.delete(); obs_b.delete();
    to_b = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clkin);
    #1;
  endtask
  task automatic test_reset;
    apply_reset(1'b0);
  endtask
  task automatic test_square;
    logic [2*W-1:0] got, want;
    apply_reset(1'b0);
    wave(1'b0, 51, 51, 5, 1);
    checks++;
    if (obs_a.size() != exp_a.size()) begin
      errors++;
      $display("FAIL square count: got %0d strobes want %0d", obs_a.size(), exp_a.size());
    end
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      got = obs_a.pop_front(); want = exp_a.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL square result: period %0d high %0d want period %0d high %0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
      end
    end
  endtask
  task automatic test_duty;
    logic [2*W-1:0] got, want;
    apply_reset(1'b0);
    wave(1'b0, 10, 30, 6, 1);
    checks++;
    if (obs_a.size() != exp_a.size()) begin
      errors++;
      $display("FAIL duty count: got %0d strobes want %0d", obs_a.size(), exp_a.size());
    end
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      got = obs_a.pop_front(); want = exp_a.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL duty result: period %0d high %0d want period %0d high %0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
      end
    end
  endtask
  task automatic test_high_at_reset;
    logic [2*W-1:0] got, want;
    apply_reset(1'b1);
    repeat (10) @(posedge clkin);
    #1;
    drive(1'b0, 1'b0);
    repeat (5) @(posedge clkin);
    #1;
    wave(1'b0, 10, 10, 4, 1);
    checks++;
    if (obs_a.size() != exp_a.size()) begin
      errors++;
      $display("FAIL high_at_reset count: got %0d strobes want %0d", obs_a.size(), exp_a.size());
    end
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      got = obs_a.pop_front(); want = exp_a.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL high_at_reset result: period %0d high %0d want period %0d high %0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
      end
    end
  endtask
  task automatic test_timeout;
    logic [2*W-1:0] got, want;
    int n;
    apply_reset(1'b0);
    wave(1'b1, 20, 30, 2, 1);
    drive(1'b1, 1'b1);
    exp_b.push_back({W'(50), W'(20)});
    n = 0;
    while (!ib.valid && n < 20) begin
      @(negedge clkin);
      n++;
    end
    checks++;
    if (!ib.valid) begin
      errors++;
      $display("FAIL timeout last_valid: valid %b after %0d cycles, want 1", ib.valid, n);
    end
    n = 0;
    do begin
      @(negedge clkin);
      n++;
    end while (!ib.timeout && n < 300);
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL timeout delay: got %0d cycles want 100", n);
    end
    checks++;
    if (dut_b.state !== IDLE) begin
      errors++;
      $display("FAIL timeout state: got %0d want %0d", dut_b.state, IDLE);
    end
    @(posedge clkin);
    #1;
    checks++;
    if (ib.timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout level: got %b want 1", ib.timeout);
    end
    wave(1'b1, 20, 30, 3, 2);
    checks++;
    if (obs_b.size() != exp_b.size()) begin
      errors++;
      $display("FAIL timeout count: got %0d strobes want %0d", obs_b.size(), exp_b.size());
    end
    while (obs_b.size() > 0 && exp_b.size() > 0) begin
      got = obs_b.pop_front(); want = exp_b.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL timeout result: period %0d high %0d want period %0d high %0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
      end
    end
    checks++;
    if (ib.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout clear: got %b want 0", ib.timeout);
    end
  endtask
  task automatic test_exact_timeout;
    logic [2*W-1:0] got, want;
    apply_reset(1'b0);
    wave(1'b1, 50, 50, 3, 1);
    drive(1'b1, 1'b1);
    exp_b.push_back({W'(100), W'(50)});
    repeat (10) @(posedge clkin);
    #1;
    checks++;
    if (obs_b.size() != exp_b.size()) begin
      errors++;
      $display("FAIL exact count: got %0d strobes want %0d", obs_b.size(), exp_b.size());
    end
    while (obs_b.size() > 0 && exp_b.size() > 0) begin
      got = obs_b.pop_front(); want = exp_b.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL exact result: period %0d high %0d want period %0d high %0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
      end
    end
    checks++;
    if (to_b !== 1'b0) begin
      errors++;
      $display("FAIL exact timeout: got %b want 0", to_b);
    end
  endtask
  task automatic test_reset_mid;
    logic [2*W-1:0] got, want;
    apply_reset(1'b0);
    wave(1'b0, 15, 15, 2, 1);
    checks++;
    if (obs_a.size() != 1 || exp_a.size() != 1 || obs_a[0] !== exp_a[0]) begin
      errors++;
      $display("FAIL reset_mid before: got %0d strobes want 1 of period 30", obs_a.size());
    end
    drive(1'b0, 1'b1);
    repeat (10) @(posedge clkin);
    #1;
    apply_reset(1'b0);
    wave(1'b0, 15, 15, 4, 1);
    checks++;
    if (obs_a.size() != exp_a.size()) begin
      errors++;
      $display("FAIL reset_mid count: got %0d strobes want %0d", obs_a.size(), exp_a.size());
    end
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      got = obs_a.pop_front(); want = exp_a.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid result: period %0d high %0d want period %0d high %0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
      end
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_square();
    test_duty();
    test_high_at_reset();
    test_timeout();
    test_exact_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Measures the period and high time of an asynchronous square-wave input, in `clkin` cycles. It reports one result per rising edge of the input, with a single-cycle `valid` strobe. It is the receive-side counterpart to our clock-divider and PWM outputs, used for encoder, echo and loop-back frequency checks on the robot board. A timeout flags a stalled or missing input.

## Interface
Parameters:
- `CNT_W`, 26: width of the internal counter and of the `period` and `high_time` outputs.
- `TIMEOUT`, 50_000_000: maximum period in cycles. Legal range is 2 to 2^CNT_W−1.

Ports:
- `clkin`  in  1: the single clock. All logic is clocked on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `sig_in`  in  1: asynchronous input, synchronised internally.
- `period`  out  CNT_W: cycles between the last two detected rising edges.
- `high_time`  out  CNT_W: cycles the input was high within that period.
- `valid`  out  1: one-cycle strobe; `period` and `high_time` are updated on the same edge.
- `timeout`  out  1: level; no rising edge was seen within `TIMEOUT` cycles.

## Operation
- Input path:
  - `sig_in` passes through a 2-flop synchroniser (s1, s2).
  - A history flop s3 holds the previous synchronised value.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- Counter `cnt`:
  - Clears to 0 on every rise accepted in ARMED or MEASURE.
  - Otherwise increments by 1 each cycle while in MEASURE.
  - Held at 0 in IDLE and ARMED.
  - Never wraps, because the timeout fires first.
- FSM states:
  - IDLE: wait for s2 == 0, then go to ARMED. This prevents a level that is already high at reset release from being counted as an edge.
  - ARMED: on rise, go to MEASURE and set `cnt` to 0. No `valid` is produced.
  - MEASURE:
    - On fall: `hi_pend` <= `cnt` + 1.
    - On rise: `period` <= `cnt` + 1, `high_time` <= `hi_pend`, `valid` <= 1, `timeout` <= 0, `cnt` <= 0. Stay in MEASURE.
    - If `cnt` == `TIMEOUT`−1 and there is no rise in that cycle: `timeout` <= 1, go to IDLE. `period` and `high_time` keep their last values.
- Simultaneous events:
  - A rise and the timeout condition in the same cycle: the rise wins, and `period` = `TIMEOUT`.
  - A rise and a fall cannot occur in the same cycle.
- `timeout` stays high until the next `valid`. Re-arming passes through IDLE and then ARMED, so the first rise after a timeout produces no result.

## Timing
- Reset values: state IDLE; s1, s2, s3, `cnt` and `hi_pend` 0; `period` 0, `high_time` 0, `valid` 0, `timeout` 0.
- Reset asserted mid-measurement aborts the measurement immediately. No `valid` is issued for it.
- Latency: a `sig_in` rise captured by s1 at edge N is detected in the cycle after edge N+1. `valid` is therefore high for the cycle following edge N+2.
- Measured values exclude synchroniser latency. Both edges see the same delay, so it cancels.
- Minimum measurable period is 2 cycles. High or low phases shorter than 1 cycle may be missed.
- The first valid result needs two rising edges after arming.

## Structure
- Shared package `meter_pkg` holds:
  - the state enum (IDLE, ARMED, MEASURE), 2-bit encoding;
  - the default `CNT_W` and `TIMEOUT` constants.
- Sub-module `sync_edge_detect` holds the 2-flop synchroniser, the history flop, and the rise and fall outputs. It takes the same `clkin` and `rst_n`.
- Everything else (FSM, counter, output registers) lives in the top level.

## Test plan
- Square wave toggling every 51 cycles (period 102, high 51): the second and later rises give `valid` with `period`=102 and `high_time`=51. The first rise after arming gives no `valid`.
- 25% duty cycle, period 40: `period`=40, `high_time`=10 on every strobe. Exactly one `valid` per period.
- `sig_in` held high through reset release, then a low pulse, then a rise every 20 cycles: no `valid` before the second rise after the low pulse; after that, `period`=20.
- `TIMEOUT`=100 and the input stops: `timeout` rises exactly 100 cycles after the last `cnt` clear, and the FSM goes to IDLE. The next valid pair of rises reports normally and clears `timeout`.
- `TIMEOUT`=100 with the input period exactly 100: `valid` with `period`=100, and `timeout` stays 0 (the simultaneous-event rule).
- `rst_n` asserted mid-period, then released with a 30-cycle input: all outputs read 0 during reset. After re-arming, `period`=30 with no stale strobe.
